vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 800, clocks per line expected.
REQ-002 The block SHALL have parameter V_TOTAL, default 525, lines per frame expected.
REQ-003 The block SHALL have parameter H_START, default 144, clocks from hsync fall to first active pixel.
REQ-004 The block SHALL have parameter V_START, default 35, lines from vsync fall to first active line.
REQ-005 The block SHALL have parameters H_ACTIVE, default 640, and V_ACTIVE, default 480, giving the active pixel and line counts.
REQ-006 The block SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames needed to lock.
REQ-007 clk  input  1  pixel clock; all state on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 hsync_n, vsync_n  input  1 each  asynchronous active-low syncs from a VGA source.
REQ-010 x, y  output  10 each  active-area pixel column and row, 0 outside active area.
REQ-011 active  output  1  high while locked and inside active area.
REQ-012 line_start, frame_start  output  1 each  one-cycle pulses on detected hsync and vsync falls.
REQ-013 locked  output  1  timing verified.
REQ-014 h_meas, v_meas  output  10 each  last measured line length in clocks and frame length in lines.
REQ-015 err  output  1  one-cycle pulse when lock is lost.

Function
REQ-016 Each sync SHALL pass a 2-flop synchronizer and then an edge register; a fall SHALL be detected when the edge register is 1 and the synchronized value is 0.
REQ-017 line_start SHALL be high for exactly one cycle, 3 rising edges after the first edge sampling hsync_n low; frame_start SHALL follow the same rule for vsync_n.
REQ-018 h_pos (10 bit) SHALL increment every cycle, saturate at 1023, and load 0 on a detected hsync fall.
REQ-019 On an hsync fall, h_meas SHALL load min(h_pos+1, 1023); the line is bad if that value differs from H_TOTAL.
REQ-020 v_pos (10 bit) SHALL increment on each hsync fall, saturating at 1023.
REQ-021 On a vsync fall, v_pos SHALL load 0 and v_meas SHALL load v_pos.
REQ-022 If hsync and vsync falls coincide, the vsync rule SHALL win for v_pos and v_meas, and the hsync rule SHALL still apply to h_pos and h_meas.
REQ-023 The frame is bad if v_meas differs from V_TOTAL, or if any bad line occurred since the previous vsync fall.
REQ-024 The FSM SHALL have states SEARCH, VERIFY and LOCKED, with good count gcnt.
REQ-025 SEARCH: on a vsync fall the FSM SHALL go to VERIFY with gcnt=0 and the frame-error flag cleared.
REQ-026 VERIFY: on a vsync fall, a good frame SHALL increment gcnt and a bad frame SHALL clear it; when gcnt reaches LOCK_FRAMES the FSM SHALL go to LOCKED.
REQ-027 LOCKED: a bad line, a bad frame, or h_pos reaching 2*H_TOTAL without an hsync fall SHALL return the FSM to SEARCH and pulse err for one cycle.
REQ-028 The h_pos timeout in VERIFY SHALL return the FSM to SEARCH without pulsing err.
REQ-029 locked SHALL be 1 exactly when the FSM state is LOCKED.
REQ-030 active, x and y SHALL be registered one cycle after h_pos and v_pos.
REQ-031 active SHALL be 1 iff locked, H_START <= h_pos < H_START+H_ACTIVE, and V_START <= v_pos < V_START+V_ACTIVE.
REQ-032 When active is 1, x SHALL equal h_pos-H_START and y SHALL equal v_pos-V_START; otherwise both SHALL be 0.

Reset
REQ-033 While rst_n is low, all outputs SHALL be 0.
REQ-034 While rst_n is low, the FSM SHALL be in SEARCH, h_pos, v_pos and gcnt SHALL be 0, and synchronizer and edge flops SHALL be 1 (sync idle).
REQ-035 Reset assertion mid-frame SHALL take effect immediately; after release the block SHALL re-acquire from SEARCH.

Verification
REQ-036 The bench SHALL cover: standard 800x525 timing, 4 frames -> locked rises 2 clocks after the third vsync-fall detection; h_meas=800, v_meas=525.
REQ-037 The bench SHALL cover: when locked, the first active pixel -> active=1, x=0, y=0; the last active pixel -> x=639, y=479; active=0 during blanking.
REQ-038 The bench SHALL cover: a single 801-clock line while locked -> err pulse of 1 cycle, locked=0, h_meas=801, then re-lock after 3 further good vsync falls.
REQ-039 The bench SHALL cover: hsync held high for 1700 clocks while locked -> timeout at h_pos=1600, err pulse, locked=0.
REQ-040 The bench SHALL cover: hsync and vsync falling on the same clock -> v_pos=0, h_pos=0, v_meas equals the prior line count.
REQ-041 The bench SHALL cover: rst_n pulsed low mid-frame while locked -> outputs 0 immediately, lock regained after reset release plus 3 vsync falls.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// Sync inputs from a VGA source and the decoded timing outputs.
// The source/bench side is the master, the decoder is the slave.
interface vga_sync_decoder_if;
  logic       hsync_n;
  logic       vsync_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic       locked;
  logic [9:0] h_meas;
  logic [9:0] v_meas;
  logic       err;

  modport master (
    output hsync_n, vsync_n,
    input  x, y, active, line_start, frame_start, locked, h_meas, v_meas, err
  );

  modport slave (
    input  hsync_n, vsync_n,
    output x, y, active, line_start, frame_start, locked, h_meas, v_meas, err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers VGA line/frame timing from raw syncs, verifies it against the
// expected totals and reports active-area pixel coordinates once locked.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input logic               clk,
  input logic               rst_n,
  vga_sync_decoder_if.slave sync_if
);
  localparam int HTO = 2 * H_TOTAL;
  localparam int TW  = $clog2(HTO + 1);
  localparam int GW  = $clog2(LOCK_FRAMES + 1) + 1;

  localparam logic [9:0]    H_TOT_L  = 10'(H_TOTAL);
  localparam logic [9:0]    V_TOT_L  = 10'(V_TOTAL);
  localparam logic [9:0]    H_ST_L   = 10'(H_START);
  localparam logic [9:0]    V_ST_L   = 10'(V_START);
  localparam logic [9:0]    H_END_L  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]    V_END_L  = 10'(V_START + V_ACTIVE);
  localparam logic [TW-1:0] HTO_L    = TW'(HTO);
  localparam logic [GW-1:0] GLOCK_L  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  logic r_hs_s1, r_hs_s2, r_hs_e;
  logic r_vs_s1, r_vs_s2, r_vs_e;
  logic w_hfall, w_vfall;

  logic [9:0]    r_h_pos, r_v_pos, r_h_meas, r_v_meas;
  logic [TW-1:0] r_hto;
  logic          r_lbad;
  logic          r_line_start, r_frame_start;

  state_t        r_state;
  logic [GW-1:0] r_gcnt;
  logic          r_locked, r_err;

  logic          r_active;
  logic [9:0]    r_x, r_y;

  logic [9:0] w_h_meas_nxt;
  logic       w_line_bad, w_frame_bad, w_timeout, w_h_in, w_v_in;

  assign w_hfall      = r_hs_e & ~r_hs_s2;
  assign w_vfall      = r_vs_e & ~r_vs_s2;
  assign w_h_meas_nxt = (r_h_pos == 10'h3FF) ? 10'h3FF : r_h_pos + 10'd1;
  assign w_line_bad   = w_hfall && (w_h_meas_nxt != H_TOT_L);
  // The line ending on this very edge still belongs to the frame being judged.
  assign w_frame_bad  = (r_v_pos != V_TOT_L) || r_lbad || w_line_bad;
  assign w_timeout    = (r_hto == HTO_L) && !w_hfall;
  assign w_h_in       = (r_h_pos >= H_ST_L) && (r_h_pos < H_END_L);
  assign w_v_in       = (r_v_pos >= V_ST_L) && (r_v_pos < V_END_L);

  // Sync stage: 2-flop synchronizers plus edge registers, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_s1 <= 1'b1; r_hs_s2 <= 1'b1; r_hs_e <= 1'b1;
      r_vs_s1 <= 1'b1; r_vs_s2 <= 1'b1; r_vs_e <= 1'b1;
    end else begin
      r_hs_s1 <= sync_if.hsync_n; r_hs_s2 <= r_hs_s1; r_hs_e <= r_hs_s2;
      r_vs_s1 <= sync_if.vsync_n; r_vs_s2 <= r_vs_s1; r_vs_e <= r_vs_s2;
    end
  end

  // Position / measurement stage; r_hto shadows h_pos without saturating at 1023
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_pos <= '0; r_v_pos <= '0; r_h_meas <= '0; r_v_meas <= '0;
      r_hto <= '0; r_lbad <= 1'b0; r_line_start <= 1'b0; r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_hfall;
      r_frame_start <= w_vfall;
      if (w_hfall) begin
        r_h_pos  <= '0;
        r_h_meas <= w_h_meas_nxt;
        r_hto    <= '0;
      end else begin
        if (r_h_pos != 10'h3FF) r_h_pos <= r_h_pos + 10'd1;
        if (r_hto != HTO_L)     r_hto   <= r_hto + TW'(1);
      end
      if (w_vfall) begin
        r_v_pos  <= '0;
        r_v_meas <= r_v_pos;
      end else if (w_hfall && (r_v_pos != 10'h3FF)) begin
        r_v_pos <= r_v_pos + 10'd1;
      end
      if (w_vfall)         r_lbad <= 1'b0;
      else if (w_line_bad) r_lbad <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SEARCH;
      r_gcnt   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        SEARCH: if (w_vfall) begin
          r_state <= VERIFY;
          r_gcnt  <= '0;
        end
        VERIFY: begin
          if (w_timeout) r_state <= SEARCH;
          else if (w_vfall) r_gcnt <= w_frame_bad ? '0 : r_gcnt + GW'(1);
          else if (r_gcnt >= GLOCK_L) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end
        end
        LOCKED: if (w_line_bad || w_timeout || (w_vfall && w_frame_bad)) begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
          r_err    <= 1'b1;
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: active area and coordinates lag h_pos/v_pos by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0; r_x <= '0; r_y <= '0;
    end else begin
      r_active <= r_locked && w_h_in && w_v_in;
      r_x      <= (r_locked && w_h_in && w_v_in) ? r_h_pos - H_ST_L : '0;
      r_y      <= (r_locked && w_h_in && w_v_in) ? r_v_pos - V_ST_L : '0;
    end
  end

  assign sync_if.x           = r_x;
  assign sync_if.y           = r_y;
  assign sync_if.active      = r_active;
  assign sync_if.line_start  = r_line_start;
  assign sync_if.frame_start = r_frame_start;
  assign sync_if.locked      = r_locked;
  assign sync_if.h_meas      = r_h_meas;
  assign sync_if.v_meas      = r_v_meas;
  assign sync_if.err         = r_err;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: 800-clock lines with a short 6-line frame; vsync falls mid line 0.
module tb_vga_sync_decoder;
  localparam int HT = 800, VT = 6, HS = 144, VS = 1, HA = 640, VA = 4, LF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_sync_decoder_if vif();

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_if(vif)
  );

  int n_cmp = 0, n_bad = 0;
  int hc = 0, vc = 0, cur_len = HT, vf_off = 400;

  // One pixel clock of source timing; after the call returning for column c,
  // DUT outputs reflect the posedge c-1 clocks after the one sampling column 0.
  task automatic tick();
    @(negedge clk);
    vif.hsync_n = (hc >= 96);
    vif.vsync_n = !(vc == 0 && hc >= vf_off);
    hc++;
    if (hc >= cur_len) begin
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end
  endtask

  task automatic run_to(input int v, input int h);
    while (!(vc == v && hc == h)) tick();
  endtask

  task automatic test_reset();
    vif.hsync_n = 1'b1; vif.vsync_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({vif.x, vif.y, vif.h_meas, vif.v_meas} !== 40'd0) begin n_bad++;
      $display("FAIL reset_bus: got %h want 0", {vif.x, vif.y, vif.h_meas, vif.v_meas}); end
    n_cmp++; if ({vif.active, vif.line_start, vif.frame_start, vif.locked, vif.err} !== 5'd0) begin n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {vif.active, vif.line_start, vif.frame_start, vif.locked, vif.err}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (vif.line_start !== 1'b0) begin n_bad++;
      $display("FAIL idle_line_start: got %b want 0", vif.line_start); end
  endtask

  task automatic test_lock();
    for (int f = 0; f < 2; f++) begin run_to(0, 400); tick(); end
    run_to(0, 400);
    repeat (4) tick();
    n_cmp++; if (vif.frame_start !== 1'b1 || vif.locked !== 1'b0) begin n_bad++;
      $display("FAIL lock_pre: frame_start=%b locked=%b want 1 0", vif.frame_start, vif.locked); end
    n_cmp++; if (vif.v_meas !== 10'(VT)) begin n_bad++;
      $display("FAIL v_meas: got %0d want %0d", vif.v_meas, VT); end
    tick();
    n_cmp++; if (vif.locked !== 1'b1 || vif.frame_start !== 1'b0) begin n_bad++;
      $display("FAIL lock_rise: locked=%b frame_start=%b want 1 0", vif.locked, vif.frame_start); end
    run_to(1, 0);
    repeat (3) tick();
    n_cmp++; if (vif.line_start !== 1'b0) begin n_bad++;
      $display("FAIL line_start_early: got %b want 0", vif.line_start); end
    tick();
    n_cmp++; if (vif.line_start !== 1'b1 || vif.h_meas !== 10'(HT)) begin n_bad++;
      $display("FAIL line_start: ls=%b h_meas=%0d want 1 %0d", vif.line_start, vif.h_meas, HT); end
    tick();
    n_cmp++; if (vif.line_start !== 1'b0) begin n_bad++;
      $display("FAIL line_start_width: got %b want 0", vif.line_start); end
  endtask

  task automatic test_active();
    run_to(1, 147); tick();
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++;
      $display("FAIL pre_active: got %b want 0", vif.active); end
    tick();
    n_cmp++; if ({vif.active, vif.x, vif.y} !== {1'b1, 10'd0, 10'd0}) begin n_bad++;
      $display("FAIL first_pixel: active=%b x=%0d y=%0d want 1 0 0", vif.active, vif.x, vif.y); end
    run_to(4, 787); tick();
    n_cmp++; if ({vif.active, vif.x, vif.y} !== {1'b1, 10'(HA - 1), 10'(VA - 1)}) begin n_bad++;
      $display("FAIL last_pixel: active=%b x=%0d y=%0d want 1 %0d %0d", vif.active, vif.x, vif.y, HA - 1, VA - 1); end
    tick();
    n_cmp++; if ({vif.active, vif.x, vif.y} !== 21'd0) begin n_bad++;
      $display("FAIL h_blank: active=%b x=%0d y=%0d want 0 0 0", vif.active, vif.x, vif.y); end
    run_to(5, 400); tick();
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++;
      $display("FAIL v_blank: got %b want 0", vif.active); end
  endtask

  task automatic relock_3_falls(input string tag);
    for (int f = 0; f < 2; f++) begin run_to(0, 400); tick(); end
    run_to(0, 400);
    repeat (4) tick();
    n_cmp++; if (vif.locked !== 1'b0) begin n_bad++;
      $display("FAIL %s_pre: locked=%b want 0", tag, vif.locked); end
    tick();
    n_cmp++; if (vif.locked !== 1'b1) begin n_bad++;
      $display("FAIL %s_relock: locked=%b want 1", tag, vif.locked); end
  endtask

  task automatic test_bad_line();
    run_to(0, 400); repeat (4) tick();
    n_cmp++; if (vif.locked !== 1'b1 || vif.err !== 1'b0) begin n_bad++;
      $display("FAIL good_frame: locked=%b err=%b want 1 0", vif.locked, vif.err); end
    run_to(3, 0); cur_len = 801;
    run_to(4, 0); cur_len = HT;
    repeat (3) tick();
    n_cmp++; if (vif.err !== 1'b0 || vif.locked !== 1'b1) begin n_bad++;
      $display("FAIL bad_line_pre: err=%b locked=%b want 0 1", vif.err, vif.locked); end
    tick();
    n_cmp++; if ({vif.err, vif.locked, vif.h_meas} !== {1'b1, 1'b0, 10'd801}) begin n_bad++;
      $display("FAIL bad_line: err=%b locked=%b h_meas=%0d want 1 0 801", vif.err, vif.locked, vif.h_meas); end
    tick();
    n_cmp++; if (vif.err !== 1'b0) begin n_bad++;
      $display("FAIL err_width: got %b want 0", vif.err); end
    relock_3_falls("bad_line");
  endtask

  task automatic test_reset_midframe();
    run_to(2, 300); tick();
    n_cmp++; if ({vif.active, vif.x, vif.y} !== {1'b1, 10'd152, 10'd1}) begin n_bad++;
      $display("FAIL mid_pixel: active=%b x=%0d y=%0d want 1 152 1", vif.active, vif.x, vif.y); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({vif.active, vif.locked, vif.x, vif.y, vif.h_meas, vif.v_meas} !== 42'd0) begin n_bad++;
      $display("FAIL async_reset: active=%b locked=%b x=%0d y=%0d h_meas=%0d v_meas=%0d want all 0",
               vif.active, vif.locked, vif.x, vif.y, vif.h_meas, vif.v_meas); end
    repeat (3) tick();
    n_cmp++; if (vif.locked !== 1'b0 || vif.line_start !== 1'b0) begin n_bad++;
      $display("FAIL held_reset: locked=%b line_start=%b want 0 0", vif.locked, vif.line_start); end
    rst_n = 1'b1;
    relock_3_falls("reset");
  endtask

  task automatic test_timeout();
    int err_cnt = 0, err_at = -1;
    run_to(3, 0); cur_len = 96 + 1700;
    for (int c = 0; c < 96 + 1700; c++) begin
      tick();
      if (vif.err === 1'b1) begin err_cnt++; if (err_at < 0) err_at = c; end
      if (c == 1603) begin
        n_cmp++; if (vif.locked !== 1'b1) begin n_bad++;
          $display("FAIL timeout_early: locked=%b want 1", vif.locked); end
      end
      if (c == 1604) begin
        n_cmp++; if (vif.locked !== 1'b0) begin n_bad++;
          $display("FAIL timeout_unlock: locked=%b want 0", vif.locked); end
      end
    end
    cur_len = HT;
    n_cmp++; if (err_cnt != 1 || err_at != 1604) begin n_bad++;
      $display("FAIL timeout_err: pulses=%0d at=%0d want 1 at 1604", err_cnt, err_at); end
  endtask

  task automatic test_coincident();
    run_to(0, 0); vf_off = 0;
    repeat (4) tick();
    n_cmp++; if (vif.line_start !== 1'b1 || vif.frame_start !== 1'b1) begin n_bad++;
      $display("FAIL coin_pulses: ls=%b fs=%b want 1 1", vif.line_start, vif.frame_start); end
    n_cmp++; if (dut.r_h_pos !== 10'd0 || dut.r_v_pos !== 10'd0) begin n_bad++;
      $display("FAIL coin_pos: h_pos=%0d v_pos=%0d want 0 0", dut.r_h_pos, dut.r_v_pos); end
    // Previous vsync fell mid line 0, so hsync falls on lines 1..VT-1 were counted.
    n_cmp++; if (vif.v_meas !== 10'(VT - 1) || vif.h_meas !== 10'(HT)) begin n_bad++;
      $display("FAIL coin_meas: v_meas=%0d h_meas=%0d want %0d %0d", vif.v_meas, vif.h_meas, VT - 1, HT); end
    run_to(1, 0); vf_off = 400;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_active();
    test_bad_line();
    test_reset_midframe();
    test_timeout();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want bench completion");
    $fatal(1, "time limit");
  end
endmodule
